// File: rtl/adder_tree_accum_ctrl_if.sv
// Stream bundle for adder_tree_accum_ctrl.
//   in_valid/in_ready/in_data : beat stream carrying 8 unsigned lanes
//   out_valid/out_ready/out_sum/out_beats : one result per job
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both high. A source holds valid and its
// payload stable until the transfer; ready may rise or fall at any time.
// modport master = client/consumer side, modport slave = the sequencer.
interface adder_tree_accum_ctrl_if #(
  parameter int ADDER_WIDTH = 11,
  parameter int CNT_W       = 5,
  parameter int ACC_WIDTH   = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic [8*ADDER_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_WIDTH-1:0]     out_sum;
  logic [CNT_W-1:0]         out_beats;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_beats
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_beats
  );
endinterface

// File: rtl/adder_tree_accum_ctrl.sv
// Job sequencer around a 2-stage pipelined 8-lane unsigned adder tree.
// A job of num_beats beats is streamed in; each beat's lane sum is added to
// an accumulator and one total is returned per job.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, num_beats  : job request (sampled only in IDLE)
//   clear             : synchronous abort back to IDLE, discards any result
//   busy              : high in any state other than IDLE
//   err               : one-cycle pulse for a start with an illegal num_beats
//   state_dbg         : current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   bus               : beat input and result output streams (slave side)
module adder_tree_accum_ctrl #(
  parameter int ADDER_WIDTH = 11,
  parameter int MAX_BEATS   = 16,
  parameter int CNT_W       = 5,
  parameter int ACC_WIDTH   = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_beats,
  input  logic             clear,
  output logic             busy,
  output logic             err,
  output logic [1:0]       state_dbg,
  adder_tree_accum_ctrl_if.slave bus
);
  localparam int TREE_W = ADDER_WIDTH + 3;
  localparam int LANES  = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       n_q;
  logic [CNT_W-1:0]       accepted_q;
  logic [CNT_W-1:0]       retired_q;
  logic [ADDER_WIDTH-1:0] lane_q [LANES];
  logic                   v1_q;
  logic [TREE_W-1:0]      tree_q;
  logic                   v2_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   out_sum_q;
  logic [CNT_W-1:0]       out_beats_q;
  logic                   out_valid_q;
  logic                   err_q;

  logic                   beats_legal;
  logic                   in_ready_int;
  logic                   in_fire;
  logic                   out_fire;
  logic                   last_accept;
  logic [TREE_W-1:0]      tree_sum;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [CNT_W-1:0]       retired_next;

  assign beats_legal  = (num_beats != '0) && (num_beats <= CNT_W'(MAX_BEATS));
  assign in_ready_int = (state_q == RUN) && (accepted_q < n_q);
  assign in_fire      = bus.in_valid && in_ready_int;
  assign out_fire     = out_valid_q && bus.out_ready;
  assign last_accept  = in_fire && ((accepted_q + CNT_W'(1)) == n_q);

  // Value the accumulator/retire counter take at this edge. Used both for
  // the pipeline update and for the DRAIN exit, so the final beat's sum is
  // captured into out_sum on the same edge it retires.
  assign acc_next     = acc_q + (v2_q ? ACC_WIDTH'(tree_q) : '0);
  assign retired_next = retired_q + CNT_W'(v2_q);

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      tree_sum = tree_sum + TREE_W'(lane_q[k]);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;
  assign err           = err_q;
  assign state_dbg     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start && beats_legal) state_d = RUN;
      RUN:     if (last_accept) state_d = DRAIN;
      DRAIN:   if (retired_next == n_q) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      accepted_q  <= '0;
      retired_q   <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      tree_q      <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (clear) begin
      // Abort: flush the pipe and drop any pending result. Lane/tree data
      // is left as is; it is dead once the valids are low.
      accepted_q  <= '0;
      retired_q   <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && start && !beats_legal;

      if (state_q == IDLE && start && beats_legal) begin
        n_q        <= num_beats;
        accepted_q <= '0;
        retired_q  <= '0;
        acc_q      <= '0;
      end else begin
        if (in_fire) accepted_q <= accepted_q + CNT_W'(1);
        if (v2_q) begin
          acc_q     <= acc_next;
          retired_q <= retired_next;
        end
      end

      // Stage 1: lane registers
      v1_q <= in_fire;
      if (in_fire) begin
        for (int k = 0; k < LANES; k++) begin
          lane_q[k] <= bus.in_data[k*ADDER_WIDTH +: ADDER_WIDTH];
        end
      end

      // Stage 2: tree register
      v2_q <= v1_q;
      if (v1_q) tree_q <= tree_sum;

      if (state_q == DRAIN && retired_next == n_q) begin
        out_sum_q   <= acc_next;
        out_beats_q <= n_q;
        out_valid_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adder_tree_accum_ctrl.sv
module tb_adder_tree_accum_ctrl;
  localparam int AW    = 11;
  localparam int MAXB  = 16;
  localparam int CW    = 5;
  localparam int ACC_W = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [CW-1:0] num_beats;
  logic          clear;
  logic          busy;
  logic          err;
  logic [1:0]    state_dbg;

  adder_tree_accum_ctrl_if #(.ADDER_WIDTH(AW), .CNT_W(CW), .ACC_WIDTH(ACC_W)) bus ();

  adder_tree_accum_ctrl #(
    .ADDER_WIDTH(AW), .MAX_BEATS(MAXB), .CNT_W(CW), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_beats (num_beats),
    .clear     (clear),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [ACC_W-1:0] exp_q[$];
  int lanes_m [MAXB][8];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are looked at 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [8*AW-1:0] pack(input int b);
    logic [8*AW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*AW +: AW] = AW'(lanes_m[b][k]);
    return v;
  endfunction

  // Reference model: the job total is simply the sum of every lane of
  // every beat; the result must appear two edges after the last accept.
  task automatic run_job(input int n, input int pat, input int cval,
                         input int gap, input int hold, input bit poke_done);
    longint s;
    logic [ACC_W-1:0] exp_sum;
    int idx, budget, accepts, first_c, last_c;
    bit hs;
    s = 0;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 8; k++) begin
        case (pat)
          0:       lanes_m[b][k] = cval;
          1:       lanes_m[b][k] = b + 1;
          default: lanes_m[b][k] = int'($urandom_range(0, 2047));
        endcase
        s += lanes_m[b][k];
      end
    end
    exp_q.push_back(ACC_W'(s));

    bus.in_valid = (gap == 0);
    bus.in_data  = pack(0);
    start = 1'b1;
    num_beats = CW'(n);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    idx = 0; accepts = 0; budget = 0; first_c = 0; last_c = 0;
    while (idx < n && budget < 300) begin
      bus.in_data = pack(idx);
      if (gap == 0)      bus.in_valid = 1'b1;
      else if (gap == 1) bus.in_valid = (budget % 2 == 0);
      else               bus.in_valid = (budget > 100) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = bus.in_valid && bus.in_ready;
      tick();
      if (hs) begin
        if (idx == 0) first_c = cyc;
        last_c = cyc;
        idx++;
        accepts++;
      end
      budget++;
    end
    chk("all_beats_accepted", idx, n);
    if (gap == 0) chk("consecutive_accepts", last_c - first_c, n - 1);

    // Keep offering junk beats: none may be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    chk("in_ready_after_last", bus.in_ready, 0);
    for (int j = 0; j < 2; j++) begin
      if (bus.in_valid && bus.in_ready) accepts++;
      tick();
      if (j == 0) chk("out_valid_early", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    chk("out_valid_latency", bus.out_valid, 1);
    chk("accept_count", accepts, n);

    exp_sum = exp_q.pop_front();
    chk("out_sum", bus.out_sum, exp_sum);
    chk("out_beats", bus.out_beats, n);

    for (int h = 0; h < hold; h++) begin
      if (poke_done && h == 2) begin
        start = 1'b1;
        num_beats = 5'd1;
      end
      tick();
      start = 1'b0;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_out_sum", bus.out_sum, exp_sum);
      chk("hold_no_err", err, 0);
    end

    // Release the result; poke_done also raises start on the same edge.
    bus.out_ready = 1'b1;
    start = poke_done;
    num_beats = 5'd1;
    tick();
    bus.out_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_take_busy", busy, 0);
    chk("idle_after_take_valid", bus.out_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int acc_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    num_beats = '0;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_beats", bus.out_beats, 0);

    // N=1 all ones -> 8
    run_job(1, 0, 1, 0, 0, 1'b0);
    // N=16 all max -> 262016
    run_job(16, 0, 2047, 0, 0, 1'b0);
    // N=4 beat i lanes = i+1, toggling valid -> 80
    run_job(4, 1, 0, 1, 0, 1'b0);
    // Backpressure, start poked during DONE and on the taking edge
    run_job(2, 0, 5, 0, 10, 1'b1);

    // Illegal job lengths
    for (int t = 0; t < 2; t++) begin
      start = 1'b1;
      num_beats = (t == 0) ? 5'd0 : 5'd17;
      tick();
      start = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_in_ready", bus.in_ready, 0);
      tick();
      chk("err_one_cycle", err, 0);
      chk("err_still_idle", busy, 0);
    end

    // Abort with clear after 3 accepts of an N=8 job
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 8; k++) lanes_m[b][k] = int'($urandom_range(0, 2047));
    start = 1'b1;
    num_beats = 5'd8;
    tick();
    start = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 20 && acc_cnt < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = pack(acc_cnt);
      if (bus.in_ready) acc_cnt++;
      tick();
    end
    chk("abort_three_accepts", acc_cnt, 3);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_no_out_valid", bus.out_valid, 0);
    end

    // Randomized jobs against the model
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, MAXB)), 2, 0, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 1'b0);
    end

    // Async reset while a result is pending
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 8; k++) lanes_m[b][k] = int'($urandom_range(1, 2047));
    start = 1'b1;
    num_beats = 5'd2;
    bus.in_valid = 1'b1;
    bus.in_data = pack(0);
    tick();
    start = 1'b0;
    tick();
    bus.in_data = pack(1);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("pre_reset_out_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_out_sum", bus.out_sum, 0);
    chk("async_rst_out_beats", bus.out_beats, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh job must carry no residue: 8*3 = 24
    run_job(1, 0, 3, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
